trap_seq: RTL and testbench

//  Executes the exceptions that csr_ctrl raises. It also executes MRET/URET returns.
//  It latches each trap event, flushes the pipeline for a fixed number of cycles, writes
//  the exception PC, cause and tval to the M or U trap registers, then sends a new PC to fetch.
//  It sits between csr_ctrl (exception/delegation source) and the fetch/PC unit.

---
 rtl/trap_seq.sv | 108 ++++++++++
 tb/tb_trap_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/trap_seq.sv
// Trap sequencer: latches exceptions and xRET returns, flushes the pipeline,
// strobes the trap CSRs for exceptions, then hands fetch a new PC.
module trap_seq #(
  parameter int FLUSH_CYCLES = 2   // legal range 1..15
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic        exc_deleg_i,
  input  logic [31:0] exc_pc_i,
  input  logic [31:0] exc_tval_i,
  input  logic        ret_valid_i,
  input  logic        ret_is_m_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] utvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] uepc_i,
  output logic        flush_o,
  output logic        busy_o,
  output logic        epc_wr_en_o,
  output logic        epc_wr_m_o,
  output logic [31:0] epc_o,
  output logic [31:0] cause_o,
  output logic [31:0] tval_o,
  output logic        redir_valid_o,
  input  logic        redir_ready_i,
  output logic [31:0] redir_pc_o
);

  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] target_q;
  logic [31:0] tvec;
  logic [31:0] xepc;

  assign tvec = exc_deleg_i ? utvec_i : mtvec_i;
  assign xepc = ret_is_m_i  ? mepc_i  : uepc_i;

  // Mode bits of tvec and bit 0 of epc are architecturally ignored.
  logic unused_bits;
  assign unused_bits = ^{tvec[1:0], xepc[0]};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= IDLE;
      cnt           <= '0;
      target_q      <= '0;
      flush_o       <= 1'b0;
      busy_o        <= 1'b0;
      epc_wr_en_o   <= 1'b0;
      epc_wr_m_o    <= 1'b0;
      epc_o         <= '0;
      cause_o       <= '0;
      tval_o        <= '0;
      redir_valid_o <= 1'b0;
      redir_pc_o    <= '0;
    end else begin
      epc_wr_en_o <= 1'b0;
      case (state)
        IDLE: begin
          // Exception has priority; a coincident xRET is dropped.
          if (exc_valid_i) begin
            state       <= FLUSH;
            cnt         <= CNT_INIT;
            flush_o     <= 1'b1;
            busy_o      <= 1'b1;
            epc_wr_en_o <= 1'b1;
            epc_wr_m_o  <= ~exc_deleg_i;
            epc_o       <= exc_pc_i;
            cause_o     <= {28'b0, exc_cause_i};
            tval_o      <= exc_tval_i;
            target_q    <= {tvec[31:2], 2'b00};
          end else if (ret_valid_i) begin
            state    <= FLUSH;
            cnt      <= CNT_INIT;
            flush_o  <= 1'b1;
            busy_o   <= 1'b1;
            target_q <= {xepc[31:1], 1'b0};
          end
        end
        FLUSH: begin
          if (cnt == 4'd0) begin
            state         <= REDIRECT;
            flush_o       <= 1'b0;
            redir_valid_o <= 1'b1;
            redir_pc_o    <= target_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        REDIRECT: begin
          if (redir_ready_i) begin
            state         <= IDLE;
            redir_valid_o <= 1'b0;
            busy_o        <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_seq.sv
// Randomized scoreboard bench for trap_seq: a cycle-phase reference model
// predicts control levels and queues expected CSR writes and redirect targets.
module tb_trap_seq;
  localparam int F = 2;

  logic        clk_i = 1'b0, rst_i = 1'b0;
  logic        exc_valid_i = 0, exc_deleg_i = 0, ret_valid_i = 0, ret_is_m_i = 0;
  logic [3:0]  exc_cause_i = 0;
  logic [31:0] exc_pc_i = 0, exc_tval_i = 0, mtvec_i = 0, utvec_i = 0, mepc_i = 0, uepc_i = 0;
  logic        redir_ready_i = 0;
  logic        flush_o, busy_o, epc_wr_en_o, epc_wr_m_o, redir_valid_o;
  logic [31:0] epc_o, cause_o, tval_o, redir_pc_o;

  trap_seq #(.FLUSH_CYCLES(F)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_deleg_i(exc_deleg_i),
    .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
    .ret_valid_i(ret_valid_i), .ret_is_m_i(ret_is_m_i),
    .mtvec_i(mtvec_i), .utvec_i(utvec_i), .mepc_i(mepc_i), .uepc_i(uepc_i),
    .flush_o(flush_o), .busy_o(busy_o), .epc_wr_en_o(epc_wr_en_o), .epc_wr_m_o(epc_wr_m_o),
    .epc_o(epc_o), .cause_o(cause_o), .tval_o(tval_o),
    .redir_valid_o(redir_valid_o), .redir_ready_i(redir_ready_i), .redir_pc_o(redir_pc_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        m;
    logic [31:0] pc;
    logic [3:0]  cause;
    logic [31:0] tval;
  } strobe_t;

  strobe_t     sq[$];
  logic [31:0] tq[$];
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 flushing (fc cycles so far), 2 redirecting.
  int ph = 0, fc = 0;
  bit first = 0, is_exc = 0;
  always @(negedge clk_i) begin
    if (!rst_i) begin
      ph = 0; first = 0;
      sq.delete(); tq.delete();
    end else begin
      chk("flush_o",       32'(flush_o),       32'(ph == 1));
      chk("busy_o",        32'(busy_o),        32'(ph != 0));
      chk("epc_wr_en_o",   32'(epc_wr_en_o),   32'(ph == 1 && first && is_exc));
      chk("redir_valid_o", 32'(redir_valid_o), 32'(ph == 2));
      case (ph)
        0: begin
          if (exc_valid_i) begin
            strobe_t s;
            s.m = ~exc_deleg_i; s.pc = exc_pc_i; s.cause = exc_cause_i; s.tval = exc_tval_i;
            sq.push_back(s);
            tq.push_back((exc_deleg_i ? utvec_i : mtvec_i) & ~32'h3);
            is_exc = 1; ph = 1; fc = 0; first = 1;
          end else if (ret_valid_i) begin
            tq.push_back((ret_is_m_i ? mepc_i : uepc_i) & ~32'h1);
            is_exc = 0; ph = 1; fc = 0; first = 1;
          end
        end
        1: begin
          first = 0; fc++;
          if (fc == F) ph = 2;
        end
        default: if (redir_ready_i) ph = 0;
      endcase
    end
  end

  // Monitor: pops expectations whenever the DUT presents a strobe or redirect.
  always @(negedge clk_i) begin
    if (rst_i) begin
      if (epc_wr_en_o) begin
        if (sq.size() == 0) chk("unexpected_strobe", 32'(epc_wr_en_o), 32'd0);
        else begin
          strobe_t s;
          s = sq.pop_front();
          chk("epc_wr_m_o", 32'(epc_wr_m_o), 32'(s.m));
          chk("epc_o",      epc_o,           s.pc);
          chk("cause_o",    cause_o,         {28'b0, s.cause});
          chk("tval_o",     tval_o,          s.tval);
        end
      end
      if (redir_valid_o) begin
        if (tq.size() == 0) chk("unexpected_redirect", 32'(redir_valid_o), 32'd0);
        else begin
          chk("redir_pc_o", redir_pc_o, tq[0]);
          if (redir_ready_i) void'(tq.pop_front());
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_exc(input logic [3:0] c, input logic d, input logic [31:0] pc, input logic [31:0] tv);
    exc_valid_i = 1; exc_cause_i = c; exc_deleg_i = d; exc_pc_i = pc; exc_tval_i = tv;
    cyc(1);
    exc_valid_i = 0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flush"},  32'(flush_o),       0);
    chk({tag, "_busy"},   32'(busy_o),        0);
    chk({tag, "_wr_en"},  32'(epc_wr_en_o),   0);
    chk({tag, "_wr_m"},   32'(epc_wr_m_o),    0);
    chk({tag, "_epc"},    epc_o,              0);
    chk({tag, "_cause"},  cause_o,            0);
    chk({tag, "_tval"},   tval_o,             0);
    chk({tag, "_rvalid"}, 32'(redir_valid_o), 0);
    chk({tag, "_rpc"},    redir_pc_o,         0);
  endtask

  initial begin
    cyc(3);
    check_all_zero("reset");
    rst_i = 1; redir_ready_i = 1;
    cyc(2);

    // ecall-U to M
    mtvec_i = 32'h2001;
    send_exc(4'd8, 1'b0, 32'h100, 32'h0);
    cyc(8);
    // delegated illegal instruction
    utvec_i = 32'h3000;
    send_exc(4'd2, 1'b1, 32'h204, 32'hDEADBEEF);
    cyc(8);
    // MRET
    mepc_i = 32'h405; ret_is_m_i = 1; ret_valid_i = 1;
    cyc(1);
    ret_valid_i = 0;
    cyc(8);
    // URET
    uepc_i = 32'h777; ret_is_m_i = 0; ret_valid_i = 1;
    cyc(1);
    ret_valid_i = 0;
    cyc(8);
    // same-cycle exc+ret, then an exc while flushing
    ret_valid_i = 1; ret_is_m_i = 1;
    send_exc(4'd11, 1'b0, 32'h500, 32'h11);
    ret_valid_i = 0;
    send_exc(4'd0, 1'b1, 32'h600, 32'h22);
    cyc(8);
    // fetch stalls the redirect
    redir_ready_i = 0;
    send_exc(4'd0, 1'b0, 32'h700, 32'h33);
    cyc(F + 6);
    redir_ready_i = 1;
    cyc(4);
    // reset during flush
    send_exc(4'd2, 1'b0, 32'h800, 32'h44);
    #3 rst_i = 0;
    #1 check_all_zero("async_rst");
    cyc(2);
    rst_i = 1;
    cyc(6);

    // randomized traffic
    repeat (600) begin
      exc_valid_i   = ($urandom % 4) == 0;
      ret_valid_i   = ($urandom % 4) == 0;
      case ($urandom % 4)
        0: exc_cause_i = 4'd0;
        1: exc_cause_i = 4'd2;
        2: exc_cause_i = 4'd8;
        default: exc_cause_i = 4'd11;
      endcase
      exc_deleg_i   = $urandom % 2;
      ret_is_m_i    = $urandom % 2;
      exc_pc_i      = $urandom; exc_tval_i = $urandom;
      mtvec_i       = $urandom; utvec_i    = $urandom;
      mepc_i        = $urandom; uepc_i     = $urandom;
      redir_ready_i = ($urandom % 3) != 0;
      cyc(1);
    end
    exc_valid_i = 0; ret_valid_i = 0; redir_ready_i = 1;
    cyc(10);
    chk("sq_drained", sq.size(), 0);
    chk("tq_drained", tq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
